ydma_hls_deadlock_report_unit: RTL and testbench

YDMA_HLS_DEADLOCK_REPORT_UNIT -- requirements
Module: ydma_hls_deadlock_report_unit

---
 rtl/ydma_hls_deadlock_pkg.sv | 25 ++
 rtl/ydma_hls_deadlock_prio_enc.sv | 31 +++
 rtl/ydma_hls_deadlock_report_unit.sv | 147 ++++++++++++++
 tb/tb_ydma_hls_deadlock_report_unit.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ydma_hls_deadlock_pkg.sv
// +----------------------------------------------------------------------+
// | ydma_hls_deadlock_pkg                                                |
// | Shared FSM state encoding and index-width helper for deadlock report |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package ydma_hls_deadlock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ORIGIN = 3'd1,
    ST_WALK   = 3'd2,
    ST_REPORT = 3'd3,
    ST_DONE   = 3'd4
  } dl_state_e;

  // Width of a process index; never narrower than one bit.
  function automatic int unsigned idw_f(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ydma_hls_deadlock_prio_enc.sv
// +----------------------------------------------------------------------+
// | ydma_hls_deadlock_prio_enc                                           |
// | Lowest-index-wins priority encoder with any-valid flag               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module ydma_hls_deadlock_prio_enc #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req_i,
  output logic [IDW-1:0] idx_o,
  output logic           vld_o
);

  // Scan high to low so the lowest set bit is the last to write idx_o.
  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o = IDW'(i);
      end
    end
  end

  assign vld_o = |req_i;

endmodule

`default_nettype wire

// File: rtl/ydma_hls_deadlock_report_unit.sv
// +----------------------------------------------------------------------+
// | ydma_hls_deadlock_report_unit                                        |
// | Latches the first deadlock origin, walks its token, reports chain    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module ydma_hls_deadlock_report_unit
  import ydma_hls_deadlock_pkg::*;
#(
  parameter int PROC_NUM = 4,
  parameter int TIMEOUT  = 16,
  localparam int IDW     = idw_f(PROC_NUM)
) (
  input  logic                reset,
  input  logic                clock,
  input  logic [PROC_NUM-1:0] dl_detect_vec,
  input  logic [PROC_NUM-1:0] token_ret_vec,
  input  logic                report_ack,
  output logic                dl_detect_in,
  output logic [PROC_NUM-1:0] origin_vec,
  output logic                token_clear,
  output logic                report_vld,
  output logic [IDW-1:0]      report_id,
  output logic [PROC_NUM-1:0] report_chain,
  output logic                report_timeout,
  output logic                deadlock_flag
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [PROC_NUM-1:0] ONE_HOT_LSB = PROC_NUM'(1);

  dl_state_e           state_q, state_d;
  logic [IDW-1:0]      origin_id_q, origin_id_d;
  logic [PROC_NUM-1:0] chain_q, chain_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic                timeout_q, timeout_d;
  logic                detected_q, detected_d;

  logic [IDW-1:0]      enc_idx;
  logic                enc_vld;
  logic [PROC_NUM-1:0] origin_onehot;
  logic                walk_ret;
  logic                walk_tmo;

  ydma_hls_deadlock_prio_enc #(
    .N   (PROC_NUM),
    .IDW (IDW)
  ) u_prio_enc (
    .req_i (dl_detect_vec),
    .idx_o (enc_idx),
    .vld_o (enc_vld)
  );

  assign origin_onehot = ONE_HOT_LSB << origin_id_q;
  // Only the origin's own detect bit means the token came home.
  assign walk_ret      = |(dl_detect_vec & origin_onehot);
  assign walk_tmo      = (timer_q == TMR_W'(TIMEOUT - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (enc_vld) state_d = ST_ORIGIN;
      ST_ORIGIN: state_d = ST_WALK;
      ST_WALK:   if (walk_ret || walk_tmo) state_d = ST_REPORT;
      ST_REPORT: if (report_ack) state_d = ST_DONE;
      ST_DONE:   state_d = ST_DONE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    origin_vec  = '0;
    token_clear = 1'b0;
    report_vld  = 1'b0;
    case (state_q)
      ST_ORIGIN: origin_vec  = origin_onehot;
      ST_WALK:   token_clear = walk_ret || walk_tmo;
      ST_REPORT: report_vld  = 1'b1;
      default:   ;
    endcase
  end

  always_comb begin
    origin_id_d = origin_id_q;
    chain_d     = chain_q;
    timer_d     = timer_q;
    timeout_d   = timeout_q;
    detected_d  = detected_q;
    case (state_q)
      ST_IDLE: begin
        if (enc_vld) begin
          origin_id_d = enc_idx;
          detected_d  = 1'b1;
        end
      end
      ST_ORIGIN: begin
        chain_d = origin_onehot;
        timer_d = '0;
      end
      ST_WALK: begin
        chain_d = chain_q | token_ret_vec;
        timer_d = (timer_q == TMR_W'(TIMEOUT)) ? timer_q : timer_q + 1'b1;
        // A return in the same cycle as the timeout wins.
        if (walk_ret) begin
          timeout_d = 1'b0;
        end else if (walk_tmo) begin
          timeout_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      origin_id_q <= '0;
      chain_q     <= '0;
      timer_q     <= '0;
      timeout_q   <= 1'b0;
      detected_q  <= 1'b0;
    end else begin
      origin_id_q <= origin_id_d;
      chain_q     <= chain_d;
      timer_q     <= timer_d;
      timeout_q   <= timeout_d;
      detected_q  <= detected_d;
    end
  end

  assign dl_detect_in   = detected_q;
  assign deadlock_flag  = detected_q;
  assign report_id      = origin_id_q;
  assign report_chain   = chain_q;
  assign report_timeout = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_ydma_hls_deadlock_report_unit.sv
// +----------------------------------------------------------------------+
// | tb_ydma_hls_deadlock_report_unit                                     |
// | Directed, scoreboard-based bench for the deadlock report unit        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_ydma_hls_deadlock_report_unit;

  logic       clock;
  logic       reset;
  logic [3:0] dl_detect_vec;
  logic [3:0] token_ret_vec;
  logic       report_ack;
  logic       dl_detect_in;
  logic [3:0] origin_vec;
  logic       token_clear;
  logic       report_vld;
  logic [1:0] report_id;
  logic [3:0] report_chain;
  logic       report_timeout;
  logic       deadlock_flag;

  typedef struct packed {
    logic [1:0] id;
    logic [3:0] chain;
    logic       tmo;
  } rpt_t;

  rpt_t sb[$];
  int   checks = 0;
  int   errors = 0;

  ydma_hls_deadlock_report_unit #(
    .PROC_NUM (4),
    .TIMEOUT  (16)
  ) dut (
    .reset          (reset),
    .clock          (clock),
    .dl_detect_vec  (dl_detect_vec),
    .token_ret_vec  (token_ret_vec),
    .report_ack     (report_ack),
    .dl_detect_in   (dl_detect_in),
    .origin_vec     (origin_vec),
    .token_clear    (token_clear),
    .report_vld     (report_vld),
    .report_id      (report_id),
    .report_chain   (report_chain),
    .report_timeout (report_timeout),
    .deadlock_flag  (deadlock_flag)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dl_in"}, dl_detect_in, 0);
    chk({tag, "_flag"},  deadlock_flag, 0);
    chk({tag, "_ovec"},  origin_vec, 0);
    chk({tag, "_tclr"},  token_clear, 0);
    chk({tag, "_vld"},   report_vld, 0);
    chk({tag, "_id"},    report_id, 0);
    chk({tag, "_chain"}, report_chain, 0);
    chk({tag, "_tmo"},   report_timeout, 0);
  endtask

  task automatic do_reset();
    reset         = 1'b0;
    dl_detect_vec = '0;
    token_ret_vec = '0;
    report_ack    = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk_all_zero("rst");
    reset = 1'b1;
  endtask

  // Waits for report_vld (bounded), then compares against the oldest expectation.
  task automatic wait_report(input int budget);
    rpt_t e;
    int   n = 0;
    while (!report_vld && n < budget) begin
      tick();
      n++;
    end
    chk("rpt_vld", report_vld, 1);
    if (sb.size() == 0) begin
      chk("rpt_sb_nonempty", 0, 1);
    end else begin
      e = sb.pop_front();
      chk("rpt_id",    report_id, e.id);
      chk("rpt_chain", report_chain, e.chain);
      chk("rpt_tmo",   report_timeout, e.tmo);
    end
  endtask

  task automatic ack_report();
    report_ack = 1'b1;
    tick();
    report_ack = 1'b0;
    #1;
    chk("ack_vld_low", report_vld, 0);
  endtask

  initial begin
    reset         = 1'b1;
    dl_detect_vec = '0;
    token_ret_vec = '0;
    report_ack    = 1'b0;

    // Origin 2, token visits 3 then 0, returns home.
    do_reset();
    dl_detect_vec = 4'b0100;
    tick();
    dl_detect_vec = '0;
    #1;
    chk("o2_dl_in", dl_detect_in, 1);
    chk("o2_flag",  deadlock_flag, 1);
    chk("o2_ovec",  origin_vec, 4'b0100);
    chk("o2_tclr0", token_clear, 0);
    sb.push_back('{2'd2, 4'b1101, 1'b0});
    tick();
    chk("o2_ovec_pulse", origin_vec, 0);
    token_ret_vec = 4'b1000;
    tick();
    token_ret_vec = 4'b0001;
    tick();
    token_ret_vec = '0;
    dl_detect_vec = 4'b0100;
    #1;
    chk("o2_tclr", token_clear, 1);
    chk("o2_vld_early", report_vld, 0);
    tick();
    dl_detect_vec = '0;
    wait_report(4);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("hold_vld",   report_vld, 1);
      chk("hold_id",    report_id, 2);
      chk("hold_chain", report_chain, 4'b1101);
      chk("hold_tmo",   report_timeout, 0);
    end
    ack_report();
    chk("done_dl_in", dl_detect_in, 1);
    chk("done_flag",  deadlock_flag, 1);
    chk("done_id",    report_id, 2);
    chk("done_chain", report_chain, 4'b1101);
    dl_detect_vec = 4'b0001;
    tick();
    chk("done_terminal_vld",  report_vld, 0);
    chk("done_terminal_ovec", origin_vec, 0);
    dl_detect_vec = '0;

    // Simultaneous detects 1 and 2: 1 wins, bit 2 ignored afterwards.
    do_reset();
    dl_detect_vec = 4'b0110;
    report_ack    = 1'b1;
    tick();
    #1;
    chk("pr_ovec", origin_vec, 4'b0010);
    sb.push_back('{2'd1, 4'b0110, 1'b0});
    dl_detect_vec = 4'b0100;
    tick();
    report_ack    = 1'b0;
    token_ret_vec = 4'b0100;
    #1;
    chk("pr_ign_bit2_a", token_clear, 0);
    tick();
    token_ret_vec = '0;
    #1;
    chk("pr_ign_bit2_b", token_clear, 0);
    dl_detect_vec = 4'b0010;
    #1;
    chk("pr_tclr", token_clear, 1);
    tick();
    dl_detect_vec = '0;
    wait_report(4);
    ack_report();

    // Origin 0, never returns: abort on the 16th WALK cycle.
    do_reset();
    dl_detect_vec = 4'b0001;
    tick();
    dl_detect_vec = '0;
    sb.push_back('{2'd0, 4'b0001, 1'b1});
    tick();
    for (int w = 1; w <= 16; w++) begin
      #1;
      chk($sformatf("tmo_clr_w%0d", w), token_clear, (w == 16) ? 1 : 0);
      if (w < 16) tick();
    end
    tick();
    wait_report(4);
    ack_report();

    // Origin 3, return lands on the timeout cycle: return wins.
    do_reset();
    dl_detect_vec = 4'b1000;
    tick();
    dl_detect_vec = '0;
    sb.push_back('{2'd3, 4'b1000, 1'b0});
    tick();
    repeat (15) tick();
    dl_detect_vec = 4'b1000;
    #1;
    chk("race_tclr", token_clear, 1);
    tick();
    dl_detect_vec = '0;
    wait_report(4);
    ack_report();

    // Reset asserted in the 3rd WALK cycle, then a fresh detection.
    do_reset();
    dl_detect_vec = 4'b0001;
    tick();
    dl_detect_vec = '0;
    tick();
    tick();
    tick();
    #2;
    reset = 1'b0;
    #1;
    chk_all_zero("midwalk");
    #3;
    reset = 1'b1;
    dl_detect_vec = 4'b0001;
    tick();
    dl_detect_vec = '0;
    #1;
    chk("re_dl_in", dl_detect_in, 1);
    chk("re_ovec",  origin_vec, 4'b0001);
    sb.push_back('{2'd0, 4'b0011, 1'b0});
    tick();
    token_ret_vec = 4'b0010;
    tick();
    token_ret_vec = '0;
    dl_detect_vec = 4'b0001;
    #1;
    chk("re_tclr", token_clear, 1);
    tick();
    dl_detect_vec = '0;
    wait_report(4);
    ack_report();

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
